// File: rtl/sram_pkg.sv
// Shared types and parameter defaults for the SRAM controller and its wait counter.
package sram_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SRAM_DW     = 64;
  localparam int DEF_SRAM_AW     = 17;
  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_BASE_ADDR   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RMW_RD  = 3'd2,
    ST_RMW_WR  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Phase timer: loaded with WAIT_CYCLES-1 at the start of a phase, counts down
// while enabled and flags the final cycle of the phase.
module sram_wait_cnt
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int                CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignment for flops so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// CPU-word to SRAM-line bridge: wait-stated reads, read-modify-write for
// sub-line stores, and direct writes when the CPU word fills a whole line.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SRAM_DW     = DEF_SRAM_DW,
  parameter int SRAM_AW     = DEF_SRAM_AW,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  localparam int WORDS = SRAM_DW / DATA_W;
  localparam int LB    = $clog2(SRAM_DW / 8);
  localparam int WB    = $clog2(DATA_W / 8);
  localparam int SEL_W = cnt_width(WORDS);
  localparam bit FULL  = (WORDS == 1);

  state_e              state_q, state_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [SRAM_DW-1:0]  line_q, line_d;
  logic                we_n_q, we_n_d;

  logic [31:0]         off;
  logic                req, cnt_load, cnt_dec, cnt_zero;

  assign req = rd_en | wr_en;
  assign off = address - 32'(BASE_ADDR);

  sram_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    line_d   = line_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d   = SRAM_AW'(off >> LB);
          sel_d    = SEL_W'(off >> WB) & SEL_W'(WORDS - 1);
          wdata_d  = wdata;
          cnt_load = 1'b1;
          if (wr_en) begin
            if (FULL) begin
              line_d  = SRAM_DW'(wdata);
              state_d = ST_WR_WAIT;
            end else begin
              state_d = ST_RMW_RD;
            end
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          rdata_d = SRAM_DQ[int'(sel_q) * DATA_W +: DATA_W];
          state_d = ST_DONE;
        end
      end

      ST_RMW_RD: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          // Merge while capturing, so the write phase just replays line_q.
          line_d                                = SRAM_DQ;
          line_d[int'(sel_q) * DATA_W +: DATA_W] = wdata_q;
          cnt_load                              = 1'b1;
          state_d                               = ST_RMW_WR;
        end
      end

      ST_RMW_WR, ST_WR_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Write strobe is registered from the next state so it never glitches on state decode.
  assign we_n_d = !((state_d == ST_RMW_WR) || (state_d == ST_WR_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      line_q  <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      line_q  <= line_d;
      we_n_q  <= we_n_d;
    end
  end

  assign SRAM_DQ   = we_n_q ? {SRAM_DW{1'bz}} : line_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_ADDR = addr_q;
  assign rdata     = rdata_q;
  assign ready     = rst | (state_q == ST_DONE) | ((state_q == ST_IDLE) & ~req);

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: a word-addressed reference memory predicts
// every access; a monitor checks latency, strobe count, line and read data.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- default-parameter instance ----------------
  logic        rst, rd_en, wr_en;
  logic [31:0] address, wdata, rdata;
  logic        ready, we_n;
  wire  [63:0] dq;
  logic [16:0] sram_addr;

  sram_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n)
  );

  // Asynchronous SRAM model: drives the bus when not being written.
  logic [63:0] mem_a [logic [16:0]];
  logic [63:0] out_a = '0;
  bit          sram_quiet = 1'b0;
  assign dq = (we_n && !sram_quiet) ? out_a : {64{1'bz}};
  always @(negedge clk) out_a = mem_a.exists(sram_addr) ? mem_a[sram_addr] : 64'd0;
  always @(posedge clk) if (!we_n) mem_a[sram_addr] = dq;

  // ---------------- full-width, single-wait instance ----------------
  logic        rd_b, wr_b, ready_b, we_n_b;
  logic [31:0] addr_b;
  logic [63:0] wdata_b, rdata_b;
  wire  [63:0] dq_b;
  logic [16:0] sram_addr_b;

  sram_ctrl #(
    .DATA_W      (64),
    .SRAM_DW     (64),
    .SRAM_AW     (17),
    .WAIT_CYCLES (1),
    .BASE_ADDR   (1024)
  ) u_dut_full (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_b),
    .wr_en     (wr_b),
    .address   (addr_b),
    .wdata     (wdata_b),
    .rdata     (rdata_b),
    .ready     (ready_b),
    .SRAM_DQ   (dq_b),
    .SRAM_ADDR (sram_addr_b),
    .SRAM_WE_N (we_n_b)
  );

  logic [63:0] mem_b [logic [16:0]];
  logic [63:0] out_b = '0;
  assign dq_b = we_n_b ? out_b : {64{1'bz}};
  always @(negedge clk) out_b = mem_b.exists(sram_addr_b) ? mem_b[sram_addr_b] : 64'd0;
  always @(posedge clk) if (!we_n_b) mem_b[sram_addr_b] = dq_b;

  // ---------------- reference model and scoreboard ----------------
  // Memory seen by the CPU as 32-bit words, indexed by (address - base) / 4.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_rd = '0;

  typedef struct {
    logic        is_wr;
    logic [31:0] rdata;
    int          low;
    int          we;
    logic [16:0] line;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   low_cnt = 0;
  int   we_cnt  = 0;
  bit   mon_en  = 1'b0;

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      low_cnt = 0;
      we_cnt  = 0;
    end else if (rd_en || wr_en) begin
      if (!ready) begin
        low_cnt++;
        if (!we_n) we_cnt++;
      end else if (sb.size() == 0) begin
        check("sb_empty", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.is_wr ? "wr_latency" : "rd_latency", 64'(low_cnt), 64'(mon_e.low));
        check("we_cycles", 64'(we_cnt), 64'(mon_e.we));
        check("sram_addr", 64'(sram_addr), 64'(mon_e.line));
        check("rdata", 64'(rdata), 64'(mon_e.rdata));
        low_cnt = 0;
        we_cnt  = 0;
      end
    end
  end

  // Caller must be at posedge+1; returns at posedge+1 after completion.
  task automatic req_a(input logic do_wr, input logic do_rd,
                       input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    logic [31:0] off, widx;
    off    = addr - 32'd1024;
    widx   = off >> 2;
    e.line = off[19:3];
    e.is_wr = do_wr;
    if (do_wr) begin
      ref_mem[widx] = data;
      e.low   = 11;
      e.we    = 5;
      e.rdata = last_rd;
    end else begin
      e.rdata = ref_mem.exists(widx) ? ref_mem[widx] : 32'd0;
      last_rd = e.rdata;
      e.low   = 6;
      e.we    = 0;
    end
    sb.push_back(e);
    rd_en   = do_rd;
    wr_en   = do_wr;
    address = addr;
    wdata   = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (!ready) check("req_timeout", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic b_access(input logic w, input logic [31:0] a, input logic [63:0] d,
                          output int lat, output int wec,
                          output logic second_we_n, output logic [16:0] line_seen);
    rd_b = !w; wr_b = w; addr_b = a; wdata_b = d;
    lat = 0; wec = 0; second_we_n = 1'b1; line_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_b) break;
      lat++;
      if (!we_n_b) wec++;
      if (lat == 2) begin
        second_we_n = we_n_b;
        line_seen   = sram_addr_b;
      end
    end
    @(posedge clk);
    #1;
    rd_b = 1'b0;
    wr_b = 1'b0;
  endtask

  logic [63:0] pre100, v, merged, dfull;
  int          nwe, lat, wec;
  logic        swe;
  logic [16:0] lseen;

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;

    mem_a[17'd0] = 64'hAAAAAAAA_BBBBBBBB;
    ref_mem[32'd0] = 32'hBBBBBBBB;
    ref_mem[32'd1] = 32'hAAAAAAAA;
    for (int l = 1; l < 16; l++) begin
      v = {$urandom, $urandom};
      mem_a[17'(l)] = v;
      ref_mem[32'(2 * l)]     = v[31:0];
      ref_mem[32'(2 * l + 1)] = v[63:32];
    end
    pre100 = {$urandom, $urandom} | 64'h1;
    mem_a[17'd100] = pre100;
    v = {$urandom, $urandom};
    mem_a[17'd101] = v;
    ref_mem[32'd202] = v[31:0];
    ref_mem[32'd203] = v[63:32];

    #22;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_we_n", 64'(we_n), 64'd1);
    check("rst_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    req_a(1'b0, 1'b1, 32'd1024, 32'd0);
    req_a(1'b0, 1'b1, 32'd1028, 32'd0);
    req_a(1'b1, 1'b0, 32'd1028, 32'h12345678);
    req_a(1'b0, 1'b1, 32'd1028, 32'd0);
    check("line0_merge", mem_a[17'd0], 64'h12345678_BBBBBBBB);
    req_a(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    req_a(1'b0, 1'b1, 32'd1032, 32'd0);
    req_a(1'b1, 1'b0, 32'd1020, 32'h0BADC0DE);
    req_a(1'b0, 1'b1, 32'd1020, 32'd0);
    req_a(1'b0, 1'b1, 32'd1016, 32'd0);

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      req_a(k != 0, k != 1, 32'd1024 + 32'($urandom_range(0, 127)), $urandom);
    end

    // Abort a read-modify-write during its third write cycle.
    mon_en  = 1'b0;
    merged  = {pre100[63:32], 32'hDEADBEEF};
    wr_en   = 1'b1;
    address = 32'd1824;
    wdata   = 32'hDEADBEEF;
    nwe     = 0;
    for (int i = 0; i < 40 && nwe < 3; i++) begin
      @(negedge clk);
      if (!we_n) nwe++;
    end
    check("rst_reached_wr", 64'(nwe), 64'd3);
    #1;
    sram_quiet = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_we_n", 64'(we_n), 64'd1);
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    check("mid_rst_dq_released", 64'(dq !== merged), 64'd1);
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sram_quiet = 1'b0;
    last_rd = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    req_a(1'b0, 1'b1, 32'd1832, 32'd0);
    req_a(1'b0, 1'b1, 32'd1836, 32'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;

    // Full-width configuration: wrapped address, no read phase before write.
    dfull = {$urandom, $urandom};
    b_access(1'b1, 32'd1016, dfull, lat, wec, swe, lseen);
    check("full_wr_latency", 64'(lat), 64'd2);
    check("full_wr_we_cycles", 64'(wec), 64'd1);
    check("full_wr_no_rmw", 64'(swe), 64'd0);
    check("full_wr_line_wrap", 64'(lseen), 64'h1FFFF);
    check("full_wr_mem", mem_b.exists(17'h1FFFF) ? mem_b[17'h1FFFF] : 64'd0, dfull);
    check("full_wr_rdata_kept", rdata_b, 64'd0);
    b_access(1'b0, 32'd1016, 64'd0, lat, wec, swe, lseen);
    check("full_rd_latency", 64'(lat), 64'd2);
    check("full_rd_we_cycles", 64'(wec), 64'd0);
    check("full_rd_rdata", rdata_b, dfull);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
